// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the control-signal pipeline: stage actions and counter sizing.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

  // What a stage register does at the next rising edge
  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,  // take upstream bundle
    ACT_HOLD   = 2'd1,  // keep current bundle
    ACT_FLUSH  = 2'd2,  // clear because the hazard unit asked for it
    ACT_BUBBLE = 2'd3   // clear because upstream is frozen but this stage moves on
  } act_e;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturating increment used by the statistics counters
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != CNT_MAX)) ? v + 1'b1 : v;
  endfunction

endpackage

// File: rtl/pipe_ctrl_stage.sv
// One control-pipeline stage: WIDTH-bit bundle plus valid, updated by an action select.
// Latency: 1 cycle from ctrl_i/valid_i to ctrl_o/valid_o on ACT_LOAD.
// Backpressure: none locally; ACT_HOLD freezes the register, the parent decides when.
module pipe_ctrl_stage
  import pipe_ctrl_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  act_e             act_i,
  input  logic [WIDTH-1:0] ctrl_i,
  input  logic             valid_i,
  output logic [WIDTH-1:0] ctrl_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] ctrl_d, ctrl_q;
  logic             valid_d, valid_q;

  // Select the next bundle from the requested action; flush and bubble both empty the slot
  always_comb begin
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    case (act_i)
      ACT_LOAD: begin
        ctrl_d  = ctrl_i;
        valid_d = valid_i;
      end
      ACT_FLUSH, ACT_BUBBLE: begin
        ctrl_d  = '0;
        valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Stage register, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
    end
  end

  assign ctrl_o  = ctrl_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/pipe_ctrl_chain.sv
// DEPTH-stage control-bundle pipeline with per-stage stall/flush, stall back-propagation and entry gating.
// Latency: ctrl_i appears on stage s output s+1 cycles after capture when nothing stalls.
// Backpressure: hold_o[s] = stall at s or any later stage; upstream logic must freeze while hold_o[0]=1.
// Optional statistics counters are built when PIPE_CTRL_STATS_EN is defined; otherwise the outputs are 0.
module pipe_ctrl_chain
  import pipe_ctrl_pkg::*;
#(
  parameter int               WIDTH     = 5,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] COND_MASK = WIDTH'(5'b11110)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       ctrl_i,
  input  logic                   valid_i,
  input  logic                   cond_pass_i,
  input  logic [DEPTH-1:0]       stall_i,
  input  logic [DEPTH-1:0]       flush_i,
  output logic [DEPTH*WIDTH-1:0] ctrl_o,
  output logic [DEPTH-1:0]       valid_o,
  output logic [DEPTH-1:0]       hold_o,
  output logic [CNT_W-1:0]       stall_cnt_o,
  output logic [CNT_W-1:0]       bubble_cnt_o
);

  logic [WIDTH-1:0] in0_ctrl;
  logic             in0_vld;
  logic [DEPTH-1:0] hold;
  logic [DEPTH-1:0] up_hold;
  act_e             act [DEPTH];
  logic [WIDTH-1:0] st_ctrl [DEPTH];
  logic             st_vld  [DEPTH];

  // Entry gating: a failed condition kills write-type enables, an invalid slot carries no control at all
  always_comb begin
    in0_vld  = valid_i;
    in0_ctrl = valid_i ? (ctrl_i & ~(COND_MASK & {WIDTH{~cond_pass_i}})) : '0;
  end

  // A stall at any stage freezes that stage and everything upstream of it
  always_comb begin
    hold            = '0;
    hold[DEPTH-1]   = stall_i[DEPTH-1];
    for (int s = DEPTH - 2; s >= 0; s--) begin
      hold[s] = stall_i[s] | hold[s+1];
    end
  end

  // Whether the stage feeding stage s is frozen (stage 0 is fed by the entry, never frozen here)
  always_comb begin
    up_hold = '0;
    for (int s = 1; s < DEPTH; s++) begin
      up_hold[s] = hold[s-1];
    end
  end

  // Per-stage action: flush beats hold beats load; a moving stage behind a frozen one takes a bubble
  always_comb begin
    for (int s = 0; s < DEPTH; s++) begin
      if (flush_i[s])      act[s] = ACT_FLUSH;
      else if (hold[s])    act[s] = ACT_HOLD;
      else if (up_hold[s]) act[s] = ACT_BUBBLE;
      else                 act[s] = ACT_LOAD;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic [WIDTH-1:0] d_ctrl;
    logic             d_vld;

    if (g == 0) begin : g_head
      assign d_ctrl = in0_ctrl;
      assign d_vld  = in0_vld;
    end else begin : g_body
      assign d_ctrl = st_ctrl[g-1];
      assign d_vld  = st_vld[g-1];
    end

    pipe_ctrl_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .act_i   (act[g]),
      .ctrl_i  (d_ctrl),
      .valid_i (d_vld),
      .ctrl_o  (st_ctrl[g]),
      .valid_o (st_vld[g])
    );

    assign ctrl_o[g*WIDTH +: WIDTH] = st_ctrl[g];
    assign valid_o[g]               = st_vld[g];
  end

  assign hold_o = hold;

`ifdef PIPE_CTRL_STATS_EN
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;
  logic             bubble_evt;

  // Count frozen-entry cycles and cycles in which any stage is emptied by flush or hold-split
  always_comb begin
    bubble_evt = 1'b0;
    for (int s = 0; s < DEPTH; s++) begin
      if ((act[s] == ACT_FLUSH) || (act[s] == ACT_BUBBLE)) bubble_evt = 1'b1;
    end
    stall_cnt_d  = sat_inc(stall_cnt_q, hold[0]);
    bubble_cnt_d = sat_inc(bubble_cnt_q, bubble_evt);
  end

  // Statistics registers, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt_o  = stall_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
`else
  assign stall_cnt_o  = '0;
  assign bubble_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// Scoreboard bench for pipe_ctrl_chain: random and directed stimulus against a queue-based reference model.
// Latency: driver pushes the expected snapshot each cycle; monitor pops on the falling edge.
// Backpressure: n/a.
module tb_pipe_ctrl_chain;

  localparam int           W    = 5;
  localparam int           D    = 2;
  localparam logic [W-1:0] MASK = 5'b11110;
`ifdef PIPE_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [W-1:0]   ctrl_i;
  logic           valid_i;
  logic           cond_pass_i;
  logic [D-1:0]   stall_i;
  logic [D-1:0]   flush_i;
  logic [D*W-1:0] ctrl_o;
  logic [D-1:0]   valid_o;
  logic [D-1:0]   hold_o;
  logic [15:0]    stall_cnt_o;
  logic [15:0]    bubble_cnt_o;

  pipe_ctrl_chain #(.WIDTH(W), .DEPTH(D), .COND_MASK(MASK)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ctrl_i       (ctrl_i),
    .valid_i      (valid_i),
    .cond_pass_i  (cond_pass_i),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .ctrl_o       (ctrl_o),
    .valid_o      (valid_o),
    .hold_o       (hold_o),
    .stall_cnt_o  (stall_cnt_o),
    .bubble_cnt_o (bubble_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [D*W-1:0] ctrl;
    logic [D-1:0]   vld;
    logic [D-1:0]   hold;
    logic [15:0]    scnt;
    logic [15:0]    bcnt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;

  // Reference model: an array of slots, each either empty or holding a bundle
  logic [W-1:0] m_ctrl [D];
  logic         m_vld  [D];
  int           m_scnt;
  int           m_bcnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // A stage is frozen if it, or any stage after it, requests a stall
  function automatic logic [D-1:0] frozen(input logic [D-1:0] st);
    logic [D-1:0] f;
    for (int s = 0; s < D; s++) f[s] = ((st >> s) != 0);
    return f;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < D; s++) begin
      m_ctrl[s] = '0;
      m_vld[s]  = 1'b0;
    end
    m_scnt = 0;
    m_bcnt = 0;
  endfunction

  function automatic void model_step(input logic [W-1:0] c, input logic v, input logic cond,
                                     input logic [D-1:0] st, input logic [D-1:0] fl);
    logic [D-1:0] f;
    logic [W-1:0] n_ctrl [D];
    logic         n_vld  [D];
    logic [W-1:0] entry;
    bit           bub;
    f   = frozen(st);
    bub = 1'b0;
    entry = !v ? '0 : (cond ? c : (c & ~MASK));
    for (int s = 0; s < D; s++) begin
      if (fl[s]) begin
        n_ctrl[s] = '0; n_vld[s] = 1'b0; bub = 1'b1;
      end else if (f[s]) begin
        n_ctrl[s] = m_ctrl[s]; n_vld[s] = m_vld[s];
      end else if (s > 0 && f[s-1]) begin
        n_ctrl[s] = '0; n_vld[s] = 1'b0; bub = 1'b1;
      end else if (s == 0) begin
        n_ctrl[s] = entry; n_vld[s] = v;
      end else begin
        n_ctrl[s] = m_ctrl[s-1]; n_vld[s] = m_vld[s-1];
      end
    end
    for (int s = 0; s < D; s++) begin
      m_ctrl[s] = n_ctrl[s];
      m_vld[s]  = n_vld[s];
    end
    if (f[0] && m_scnt < 65535) m_scnt++;
    if (bub && m_bcnt < 65535) m_bcnt++;
  endfunction

  // Apply one cycle of inputs (called at posedge+1), record what the DUT must show before the next edge
  task automatic cycle(input logic [W-1:0] c, input logic v, input logic cond,
                       input logic [D-1:0] st, input logic [D-1:0] fl);
    exp_t e;
    ctrl_i = c; valid_i = v; cond_pass_i = cond; stall_i = st; flush_i = fl;
    for (int s = 0; s < D; s++) begin
      e.ctrl[s*W +: W] = m_ctrl[s];
      e.vld[s]         = m_vld[s];
    end
    e.hold = frozen(st);
    e.scnt = STATS ? 16'(m_scnt) : 16'd0;
    e.bcnt = STATS ? 16'(m_bcnt) : 16'd0;
    sb.push_back(e);
    model_step(c, v, cond, st, fl);
    mon_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_cycle();
    logic [D-1:0] st;
    logic [D-1:0] fl;
    for (int s = 0; s < D; s++) begin
      st[s] = ($urandom_range(0, 4) == 0);
      fl[s] = ($urandom_range(0, 7) == 0);
    end
    cycle(W'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, st, fl);
  endtask

  // Assert reset between edges and confirm everything clears without waiting for a clock
  task automatic async_reset();
    mon_en = 1'b0;
    ctrl_i = '0; valid_i = 1'b0; cond_pass_i = 1'b1; stall_i = '0; flush_i = '0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_ctrl",  32'(ctrl_o), 32'd0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_scnt",  32'(stall_cnt_o), 32'd0);
    check("rst_bcnt",  32'(bubble_cnt_o), 32'd0);
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every falling edge while active, the DUT must match the oldest expected snapshot
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_empty: got no expected entry, required one per cycle");
      end else begin
        e = sb.pop_front();
        check("sb_ctrl",  32'(ctrl_o),       32'(e.ctrl));
        check("sb_valid", 32'(valid_o),      32'(e.vld));
        check("sb_hold",  32'(hold_o),       32'(e.hold));
        check("sb_scnt",  32'(stall_cnt_o),  32'(e.scnt));
        check("sb_bcnt",  32'(bubble_cnt_o), 32'(e.bcnt));
      end
    end
  end

  initial begin
    ctrl_i = '0; valid_i = 1'b0; cond_pass_i = 1'b1; stall_i = '0; flush_i = '0;
    model_reset();
    #12;
    check("init_ctrl",  32'(ctrl_o), 32'd0);
    check("init_valid", 32'(valid_o), 32'd0);
    check("init_scnt",  32'(stall_cnt_o), 32'd0);
    check("init_bcnt",  32'(bubble_cnt_o), 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    repeat (700) rand_cycle();

    // Fill both stages with valid data, then reset mid-stream
    cycle(5'b10101, 1'b1, 1'b1, 2'b00, 2'b00);
    cycle(5'b01110, 1'b1, 1'b1, 2'b00, 2'b00);
    check("full_valid", 32'(valid_o), 32'd3);
    async_reset();

    // Flow-through
    cycle(5'b01011, 1'b1, 1'b1, 2'b00, 2'b00);
    check("flow_s0", 32'(ctrl_o[4:0]), 32'h0B);
    check("flow_v0", 32'(valid_o[0]), 32'd1);
    cycle(5'b00000, 1'b0, 1'b1, 2'b00, 2'b00);
    check("flow_s1", 32'(ctrl_o[9:5]), 32'h0B);
    check("flow_v1", 32'(valid_o[1]), 32'd1);
    check("flow_s0_idle", 32'(ctrl_o[4:0]), 32'd0);

    // Condition failure keeps valid but drops masked enables
    cycle(5'b11111, 1'b1, 1'b0, 2'b00, 2'b00);
    check("cond_s0", 32'(ctrl_o[4:0]), 32'h01);
    check("cond_v0", 32'(valid_o[0]), 32'd1);

    // Stall split: stage 0 frozen, stage 1 drains into a bubble
    cycle(5'b10110, 1'b1, 1'b1, 2'b00, 2'b00);
    cycle(5'b01111, 1'b1, 1'b1, 2'b01, 2'b00);
    check("split_hold", 32'(hold_o), 32'd1);
    check("split_s0", 32'(ctrl_o[4:0]), 32'h16);
    check("split_s1", 32'(ctrl_o[9:5]), 32'd0);
    check("split_v1", 32'(valid_o[1]), 32'd0);
    cycle(5'b01111, 1'b1, 1'b1, 2'b01, 2'b00);
    check("split2_s0", 32'(ctrl_o[4:0]), 32'h16);
    cycle(5'b01111, 1'b1, 1'b1, 2'b10, 2'b00);
    check("freeze_hold", 32'(hold_o), 32'd3);
    check("freeze_s0", 32'(ctrl_o[4:0]), 32'h16);
    check("freeze_v", 32'(valid_o), 32'd1);

    // Flush and stall on the same stage: it clears, upstream still held
    cycle(5'b00111, 1'b1, 1'b1, 2'b00, 2'b00);
    cycle(5'b11000, 1'b1, 1'b1, 2'b10, 2'b10);
    check("fs_s1", 32'(ctrl_o[9:5]), 32'd0);
    check("fs_v1", 32'(valid_o[1]), 32'd0);
    check("fs_s0", 32'(ctrl_o[4:0]), 32'h07);
    check("fs_hold", 32'(hold_o), 32'd3);
    cycle(5'b00000, 1'b0, 1'b1, 2'b00, 2'b00);

    repeat (800) rand_cycle();

    // Statistics: three full stalls then a single flush
    async_reset();
    repeat (3) cycle(5'b00000, 1'b0, 1'b1, 2'b11, 2'b00);
    cycle(5'b00000, 1'b0, 1'b1, 2'b00, 2'b01);
    check("stat_scnt", 32'(stall_cnt_o), STATS ? 32'd3 : 32'd0);
    check("stat_bcnt", 32'(bubble_cnt_o), STATS ? 32'd1 : 32'd0);

    // Saturation: long hold-split run drives both counters past their range
    repeat (70000) cycle(W'($urandom), 1'b1, 1'b1, 2'b01, 2'b00);
    check("sat_scnt", 32'(stall_cnt_o), STATS ? 32'hFFFF : 32'd0);
    check("sat_bcnt", 32'(bubble_cnt_o), STATS ? 32'hFFFF : 32'd0);

    mon_en = 1'b0;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_leftover: got %0d pending entries, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
